// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: reduces every KROWS psums into one pixel over a start/done-controlled run,
// with valid/ready backpressure on both the psum input and the pixel output.
module psum_accum_ctrl #(
  parameter int DATA_W = 16,
  parameter int KROWS  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_out_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              psum_valid_i,
  input  logic [DATA_W-1:0] psum_data_i,
  output logic              psum_ready_o,
  output logic              acc_valid_o,
  output logic [DATA_W-1:0] acc_data_o,
  output logic              acc_last_o,
  input  logic              acc_ready_i
);
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [7:0]        row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, num_q, num_d;
  logic [DATA_W-1:0] acc_q, acc_d, out_q, out_d, sum;
  logic              last_row, last_pix;
  assign sum          = (row_q == '0) ? psum_data_i : acc_q + psum_data_i;
  assign last_row     = row_q == 8'(KROWS - 1);
  assign last_pix     = cnt_q == num_q - CNT_W'(1);
  assign busy_o       = state_q != IDLE;
  assign done_o       = state_q == DONE;
  assign psum_ready_o = state_q == ACCUM;
  assign acc_valid_o  = state_q == EMIT;
  assign acc_last_o   = acc_valid_o & last_pix;
  assign acc_data_o   = out_q;
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (start_i) begin
        num_d   = num_out_i;
        cnt_d   = '0;
        row_d   = '0;
        acc_d   = '0;
        state_d = (num_out_i == '0) ? DONE : ACCUM;
      end
      ACCUM: if (psum_valid_i) begin
        acc_d   = sum;
        row_d   = last_row ? '0 : row_q + 8'd1;
        out_d   = last_row ? sum : out_q;
        state_d = last_row ? EMIT : ACCUM;
      end
      EMIT: if (acc_ready_i) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last_pix ? DONE : ACCUM;
      end
      default: state_d = IDLE;
    endcase
    // abort drops the run and scrubs partial state; the last emitted pixel value is kept
    if (abort_i) begin
      state_d = IDLE;
      row_d   = '0;
      cnt_d   = '0;
      num_d   = '0;
      acc_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb_psum_accum_ctrl: vector table, directed corner sequences and randomized runs against a group-sum model.
module tb_psum_accum_ctrl;
  localparam int DW = 16, KR = 3, CW = 16;
  logic clk = 0, rst = 1;
  logic start_i = 0, abort_i = 0, psum_valid_i = 0, acc_ready_i = 0;
  logic [CW-1:0] num_out_i = '0;
  logic [DW-1:0] psum_data_i = '0;
  logic [DW-1:0] acc_data_o;
  logic busy_o, done_o, psum_ready_o, acc_valid_o, acc_last_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  psum_accum_ctrl #(.DATA_W(DW), .KROWS(KR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_out_i(num_out_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .psum_valid_i(psum_valid_i), .psum_data_i(psum_data_i),
    .psum_ready_o(psum_ready_o), .acc_valid_o(acc_valid_o), .acc_data_o(acc_data_o),
    .acc_last_o(acc_last_o), .acc_ready_i(acc_ready_i)
  );
  typedef struct {
    logic st; logic [15:0] num; logic pv; logic [15:0] pd; logic ar;
    logic b, d, pr, av, al; logic [15:0] ad;
  } vec_t;
  vec_t tv[10];
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic run(input logic [CW-1:0] n);
    start_i = 1; num_out_i = n; step(); start_i = 0;
  endtask
  task automatic push(input logic [DW-1:0] d);
    int k = 0;
    psum_valid_i = 1; psum_data_i = d;
    while (!psum_ready_o && k < 50) begin step(); k++; end
    if (k >= 50) chk("push_timeout", 1, 0);
    step(); psum_valid_i = 0;
  endtask
  task automatic pop(input string n, input logic [DW-1:0] d, input logic l);
    int k = 0;
    acc_ready_i = 1;
    while (!acc_valid_o && k < 50) begin step(); k++; end
    chk({n, "_valid"}, acc_valid_o, 1);
    chk({n, "_data"}, acc_data_o, d);
    chk({n, "_last"}, acc_last_o, l);
    step(); acc_ready_i = 0;
  endtask
  initial begin
    logic [DW-1:0] ps[$], exp_px[$], s;
    int num, pi, po, dn, cyc;
    step(); step();
    chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0); chk("rst_pready", psum_ready_o, 0);
    chk("rst_avalid", acc_valid_o, 0); chk("rst_alast", acc_last_o, 0); chk("rst_adata", acc_data_o, 0);
    rst = 0;
    tv[0] = '{1, 2, 0, 0,  1, 1, 0, 1, 0, 0, 0};
    tv[1] = '{0, 0, 1, 1,  1, 1, 0, 1, 0, 0, 0};
    tv[2] = '{0, 0, 1, 2,  1, 1, 0, 1, 0, 0, 0};
    tv[3] = '{0, 0, 1, 3,  1, 1, 0, 0, 1, 0, 6};
    tv[4] = '{0, 0, 1, 10, 1, 1, 0, 1, 0, 0, 6};
    tv[5] = '{0, 0, 1, 10, 1, 1, 0, 1, 0, 0, 6};
    tv[6] = '{0, 0, 1, 20, 1, 1, 0, 1, 0, 0, 6};
    tv[7] = '{0, 0, 1, 30, 1, 1, 0, 0, 1, 1, 60};
    tv[8] = '{0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 60};
    tv[9] = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 60};
    for (int i = 0; i < 10; i++) begin
      start_i = tv[i].st; num_out_i = tv[i].num; psum_valid_i = tv[i].pv;
      psum_data_i = tv[i].pd; acc_ready_i = tv[i].ar;
      step();
      chk($sformatf("vec%0d_busy", i), busy_o, tv[i].b);
      chk($sformatf("vec%0d_done", i), done_o, tv[i].d);
      chk($sformatf("vec%0d_pready", i), psum_ready_o, tv[i].pr);
      chk($sformatf("vec%0d_avalid", i), acc_valid_o, tv[i].av);
      chk($sformatf("vec%0d_alast", i), acc_last_o, tv[i].al);
      chk($sformatf("vec%0d_adata", i), acc_data_o, tv[i].ad);
    end
    start_i = 0; psum_valid_i = 0; acc_ready_i = 0;
    // carry out of the top bit is discarded and does not bleed into the next pixel
    run(2);
    push(16'hFFFF); push(16'h0002); push(16'h0000);
    pop("wrap", 16'h0001, 0);
    push(5); push(6); push(7);
    pop("wrap2", 18, 1);
    chk("wrap_done", done_o, 1);
    step();
    chk("wrap_idle", busy_o, 0);
    // downstream stall holds the pixel and blocks upstream
    run(2);
    push(1); push(2); push(3);
    psum_valid_i = 1; psum_data_i = 9;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp%0d_avalid", i), acc_valid_o, 1);
      chk($sformatf("bp%0d_adata", i), acc_data_o, 6);
      chk($sformatf("bp%0d_pready", i), psum_ready_o, 0);
      step();
    end
    pop("bp", 6, 0);
    push(9); push(1); push(1);
    pop("bp2", 11, 1);
    chk("bp_done", done_o, 1);
    step();
    // upstream bubbles carry junk data that must be ignored
    run(1);
    acc_ready_i = 0;
    psum_valid_i = 1; psum_data_i = 4;  step();
    psum_valid_i = 0; psum_data_i = 99; step();
    psum_valid_i = 1; psum_data_i = 5;  step();
    psum_valid_i = 0; psum_data_i = 77; step();
    psum_valid_i = 1; psum_data_i = 6;  step();
    psum_valid_i = 0;
    chk("bub_avalid", acc_valid_o, 1); chk("bub_adata", acc_data_o, 15); chk("bub_alast", acc_last_o, 1);
    acc_ready_i = 1; step(); acc_ready_i = 0;
    chk("bub_done", done_o, 1);
    step();
    // zero-length run
    run(0);
    chk("zero_done", done_o, 1); chk("zero_busy", busy_o, 1); chk("zero_avalid", acc_valid_o, 0);
    step();
    chk("zero_done2", done_o, 0); chk("zero_busy2", busy_o, 0); chk("zero_avalid2", acc_valid_o, 0);
    // start while busy must not restart or resize the run
    run(2);
    push(1); push(1);
    start_i = 1; num_out_i = 5; step(); start_i = 0;
    push(1);
    pop("mid", 3, 0);
    push(2); push(2); push(2);
    pop("mid2", 6, 1);
    chk("mid_done", done_o, 1);
    step();
    chk("mid_idle", busy_o, 0);
    // abort and reset both discard a partial pixel
    for (int m = 0; m < 2; m++) begin
      run(1);
      push(7); push(8);
      if (m == 0) abort_i = 1; else rst = 1;
      step(); abort_i = 0; rst = 0;
      chk($sformatf("ab%0d_busy", m), busy_o, 0);
      chk($sformatf("ab%0d_done", m), done_o, 0);
      chk($sformatf("ab%0d_pready", m), psum_ready_o, 0);
      chk($sformatf("ab%0d_avalid", m), acc_valid_o, 0);
      if (m == 1) chk("rst_mid_adata", acc_data_o, 0);
      run(1);
      push(1); push(1); push(1);
      pop($sformatf("ab%0d", m), 3, 1);
      chk($sformatf("ab%0d_fin", m), done_o, 1);
      step();
    end
    // randomized runs with random bubbles and stalls
    for (int r = 0; r < 20; r++) begin
      num = $urandom_range(1, 4);
      ps.delete(); exp_px.delete();
      for (int p = 0; p < num; p++) begin
        s = '0;
        for (int j = 0; j < KR; j++) begin
          ps.push_back(DW'($urandom));
          s = s + ps[ps.size() - 1];
        end
        exp_px.push_back(s);
      end
      run(CW'(num));
      pi = 0; po = 0; dn = 0; cyc = 0;
      while (!(po == num && dn != 0) && cyc < 2000) begin
        psum_valid_i = (pi < ps.size()) && ($urandom_range(0, 3) != 0);
        psum_data_i = (pi < ps.size()) ? ps[pi] : DW'($urandom);
        acc_ready_i = $urandom_range(0, 2) != 0;
        if (acc_valid_o && acc_ready_i) begin
          chk($sformatf("rnd%0d_px%0d_data", r, po), acc_data_o, exp_px[po]);
          chk($sformatf("rnd%0d_px%0d_last", r, po), acc_last_o, po == num - 1);
          po++;
        end
        if (psum_valid_i && psum_ready_o) pi++;
        if (done_o) dn++;
        step(); cyc++;
      end
      psum_valid_i = 0; acc_ready_i = 0;
      chk($sformatf("rnd%0d_pixels", r), po, num);
      chk($sformatf("rnd%0d_psums", r), pi, ps.size());
      chk($sformatf("rnd%0d_done", r), dn, 1);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
